// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one request at a time,
// fixed wait states, then a one-cycle completion strobe.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] CNT_INIT =
    (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic commit;
  logic req;

  logic [31:0] a_q, d_q;
  logic [3:0]  be_q;
  logic        wr_q;

  logic [31:0] cur_a, cur_d;
  logic [3:0]  cur_be;
  logic        cur_wr;
  logic        cur_err;
  logic [ADDR_WIDTH-1:0] idx;

  logic [31:0] mem [2**ADDR_WIDTH];

  assign req = mem_re | mem_we;

  // With zero latency the commit edge is the acceptance edge,
  // so the live inputs are used instead of the latched copy.
  always_comb begin
    cur_a  = a_q;
    cur_d  = d_q;
    cur_be = be_q;
    cur_wr = wr_q;
    if (state == IDLE) begin
      cur_a  = addr;
      cur_d  = wdata;
      cur_be = byte_en;
      cur_wr = mem_we;
    end
  end

  assign cur_err = (cur_a[1:0] != 2'b00) |
                   ((cur_a >> (ADDR_WIDTH + 2)) != 32'd0);
  assign idx = cur_a[ADDR_WIDTH+1:2];

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    commit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (LATENCY == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      a_q       <= 32'd0;
      d_q       <= 32'd0;
      be_q      <= 4'd0;
      wr_q      <= 1'b0;
      rdata     <= 32'd0;
      mem_ready <= 1'b0;
      mem_busy  <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      mem_ready <= commit;
      mem_busy  <= (state_d != IDLE);
      addr_err  <= commit & cur_err;
      if (state == IDLE && req) begin
        a_q  <= addr;
        d_q  <= wdata;
        be_q <= byte_en;
        wr_q <= mem_we;
      end
      if (commit && !cur_wr) begin
        rdata <= cur_err ? 32'd0 : mem[idx];
      end
    end
  end

  // Array is not reset; a reset edge suppresses any pending commit.
  always_ff @(posedge clk) begin
    if (!reset && commit && cur_wr && !cur_err) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) begin
          mem[idx][8*i +: 8] <= cur_d[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and 0)
// checked against a word-array reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        re, we, sel;
  logic [31:0] addr, wdata;
  logic [3:0]  be;

  logic [31:0] rd0, rd1;
  logic        rdy0, rdy1, bsy0, bsy1, er0, er1;
  logic [31:0] o_rd;
  logic        o_rdy, o_bsy, o_er;

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl [2][1024];
  logic [31:0] exp_rd [2];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset),
    .mem_re(re & ~sel), .mem_we(we & ~sel),
    .addr(addr), .wdata(wdata), .byte_en(be),
    .rdata(rd0), .mem_ready(rdy0),
    .mem_busy(bsy0), .addr_err(er0)
  );

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset),
    .mem_re(re & sel), .mem_we(we & sel),
    .addr(addr), .wdata(wdata), .byte_en(be),
    .rdata(rd1), .mem_ready(rdy1),
    .mem_busy(bsy1), .addr_err(er1)
  );

  assign o_rd  = sel ? rd1  : rd0;
  assign o_rdy = sel ? rdy1 : rdy0;
  assign o_bsy = sel ? bsy1 : bsy0;
  assign o_er  = sel ? er1  : er0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  task automatic issue(input bit w, input bit r,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [3:0] b);
    @(negedge clk);
    re = r; we = w; addr = a; wdata = d; be = b;
    @(posedge clk);
  endtask

  // Called right after the acceptance edge.
  task automatic complete(input bit w,
                          input logic [31:0] a,
                          input logic [31:0] d,
                          input logic [3:0] b,
                          input bit hold);
    int  k;
    bit  seen;
    bit  err;
    int  lat;
    int  s;
    k = 0;
    seen = 0;
    s = sel ? 1 : 0;
    lat = sel ? 0 : 2;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (n == 0 && !hold) begin
        re = 0; we = 0;
        addr = $urandom; wdata = $urandom; be = 4'($urandom);
      end
      if (o_rdy === 1'b1) seen = 1;
      else begin
        chk("busy_wait", 32'(o_bsy), 32'd1);
        k++;
      end
    end
    chk("ready_seen", 32'(seen), 32'd1);
    chk("latency", 32'(k), 32'(lat));
    err = (a[1:0] != 2'b00) || ((a >> 12) != 32'd0);
    if (w) begin
      if (!err)
        for (int i = 0; i < 4; i++)
          if (b[i]) mdl[s][a[11:2]][8*i +: 8] = d[8*i +: 8];
    end else begin
      exp_rd[s] = err ? 32'd0 : mdl[s][a[11:2]];
    end
    chk("addr_err", 32'(o_er), 32'(err));
    chk("rdata", o_rd, exp_rd[s]);
    chk("busy_resp", 32'(o_bsy), 32'd1);
    @(negedge clk);
    chk("ready_fall", 32'(o_rdy), 32'd0);
    chk("busy_fall", 32'(o_bsy), 32'd0);
    chk("err_idle", 32'(o_er), 32'd0);
  endtask

  task automatic op(input bit w, input bit r,
                    input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [3:0] b);
    issue(w, r, a, d, b);
    complete(w | (w & r), a, d, b, 1'b0);
  endtask

  initial begin
    logic [31:0] ra;
    int sel_r, kind, rw;
    reset = 1; re = 1; we = 1; sel = 0;
    addr = 32'h100; wdata = 32'h1; be = 4'hf;
    exp_rd[0] = 0;
    exp_rd[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", rd0, 32'd0);
    chk("rst_ready", 32'(rdy0), 32'd0);
    chk("rst_busy", 32'(bsy0), 32'd0);
    chk("rst_err", 32'(er0), 32'd0);
    chk("rst_rdata1", rd1, 32'd0);
    chk("rst_busy1", 32'(bsy1), 32'd0);
    re = 0; we = 0; reset = 0;
    @(negedge clk);
    chk("post_rst_busy", 32'(bsy0), 32'd0);

    op(1, 0, 32'h100, 32'hDEADBEEF, 4'hf);
    op(0, 1, 32'h100, 32'h0, 4'h0);
    chk("rd_deadbeef", o_rd, 32'hDEADBEEF);
    op(1, 0, 32'h100, 32'h000000AA, 4'b0001);
    op(0, 1, 32'h100, 32'h0, 4'h0);
    chk("rd_be0001", o_rd, 32'hDEADBEAA);
    op(1, 0, 32'h100, 32'h55555555, 4'b0000);
    op(0, 1, 32'h100, 32'h0, 4'hf);
    chk("rd_be0000", o_rd, 32'hDEADBEAA);
    op(0, 1, 32'h3, 32'h0, 4'h0);
    op(1, 0, 32'h1000, 32'h77777777, 4'hf);
    op(0, 1, 32'h100, 32'h0, 4'h0);
    op(1, 1, 32'h104, 32'h12345678, 4'hf);
    op(0, 1, 32'h104, 32'h0, 4'h0);
    chk("rd_collision", o_rd, 32'h12345678);

    issue(0, 1, 32'h100, 32'h0, 4'h0);
    complete(0, 32'h100, 32'h0, 4'h0, 1'b1);
    @(posedge clk);
    complete(0, 32'h100, 32'h0, 4'h0, 1'b0);

    issue(1, 0, 32'h104, 32'hCAFEF00D, 4'hf);
    @(negedge clk);
    re = 0; we = 0;
    chk("mid_busy", 32'(o_bsy), 32'd1);
    reset = 1;
    @(negedge clk);
    chk("abort_busy", 32'(o_bsy), 32'd0);
    chk("abort_ready", 32'(o_rdy), 32'd0);
    chk("abort_rdata", o_rd, 32'd0);
    exp_rd[0] = 0;
    reset = 0;
    repeat (4) @(negedge clk);
    chk("abort_noresp", 32'(o_rdy | o_bsy), 32'd0);
    op(0, 1, 32'h104, 32'h0, 4'h0);
    chk("rd_after_abort", o_rd, 32'h12345678);

    sel = 1;
    op(1, 0, 32'h100, 32'hDEADBEEF, 4'hf);
    op(0, 1, 32'h100, 32'h0, 4'h0);
    chk("l0_rd", o_rd, 32'hDEADBEEF);

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 16; i++)
        op(1, 0, 32'(i * 4), $urandom, 4'hf);
    end
    for (int t = 0; t < 80; t++) begin
      sel_r = $urandom_range(0, 1);
      sel = sel_r[0];
      kind = $urandom_range(0, 7);
      ra = 32'($urandom_range(0, 15) * 4);
      if (kind == 0) ra = ra | 32'($urandom_range(1, 3));
      if (kind == 1) ra = ($urandom | 32'h1000) & ~32'h3;
      rw = $urandom_range(0, 2);
      op(rw != 0, rw != 1, ra, $urandom, 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
